lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store control unit sitting between the memory stage of the 3-stage pipeline and the data-side slaves: `Data_Mem` and the UART register block. It decodes load/store requests, routes them by address, sign- or zero-extends load data, and performs sub-word stores into the word-only data memory with a two-cycle read-modify-write, stalling the pipeline for one cycle.

## Interface
- Parameters: none. Address map and opcodes are package constants.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  memory-stage request present.
- `is_load`  in  1  request is a load.
- `is_store`  in  1  request is a store. `is_load` and `is_store` are never both 1.
- `funct3`  in  3  RV32I width and sign field.
- `addr`  in  32  effective byte address.
- `store_data`  in  32  rs2 value.
- `load_data`  out  32  extended load result, combinational.
- `stall`  out  1  holds the pipeline; the request inputs are held stable while this is 1.
- `access_fault`  out  1  illegal access; combinational.
- `lsu2dmem_data`  out  `type_lsu2module_data_s`  fields `dbus_addr`, `dbus`, `wr_en`, `rd_en`, `sel` to `Data_Mem`.
- `dmem2lsu_data`  in  `type_module2lsu_s`  `rd_data`, combinational from `Data_Mem`.
- `lsu2uart_data`  out  `type_lsu2module_data_s`  same fields, to the UART.
- `uart2lsu_data`  in  `type_module2lsu_s`  UART read data.

## Operation
- Address decode:
  - DMEM when `addr[31]`=0; UART when `addr[31]`=1.
  - Only the selected slave gets `sel`=1. The other slave's struct is all-zero.
- Memory byte order: `Data_Mem` returns and writes the 4 bytes starting at `dbus_addr`.
  - The addressed byte is therefore always lane 0, aligned or not.
  - No alignment shifting is performed.
- Loads, single cycle, `stall`=0:
  - Drive `rd_en`=1, `sel`=1, `dbus_addr`=`addr`.
  - LB/LH/LW/LBU/LHU (000/001/010/100/101) produce sext(rd[7:0]), sext(rd[15:0]), rd, zext(rd[7:0]), zext(rd[15:0]).
  - `load_data`=0 when not loading.
- SW, and any store to UART: single cycle.
  - `wr_en`=1, `dbus`=`store_data`; the write commits at the rising edge.
  - UART stores of any width pass `store_data` unmodified.
- SB/SH to DMEM: FSM with states IDLE and RMW_WR.
  - IDLE, request seen:
    - Drive `rd_en`=1 and `stall`=1.
    - At the edge, register `wbuf` = {rd[31:8], sd[7:0]} for SB or {rd[31:16], sd[15:0]} for SH.
    - Register `addr_q`=`addr[10:0]` and go to RMW_WR.
  - RMW_WR:
    - Drive `wr_en`=1, `dbus`=`wbuf`, `dbus_addr`=`addr_q`, `stall`=0.
    - Request inputs are ignored.
    - Return to IDLE at the next edge.
- Fault (`access_fault`=1, no `rd_en`/`wr_en`, `stall`=0), when any of:
  - funct3 is 011, 110 or 111;
  - a store funct3 is above 010;
  - a DMEM access has `addr[10:0]` > 0x7FC (word would wrap past the top of memory).

## Timing
- Reset values (asynchronous): state IDLE, `wbuf`=0, `addr_q`=0.
  - With `req_valid`=0, every output is 0.
- Latency:
  - Loads: combinational, same cycle.
  - SW: commits at the end of the request cycle.
  - SB/SH: 2 cycles, with `stall` high in the first cycle only; memory is updated at the end of cycle 2.
- Reset asserted in RMW_WR: the pending write is dropped, the FSM goes to IDLE, DMEM is unchanged.
- A request with `req_valid`=0 in IDLE does nothing.
- Back-to-back sub-word stores: IDLE→RMW_WR→IDLE→RMW_WR. There is no bubble beyond the one stall cycle per store.
- A load arriving in the cycle right after RMW_WR sees the written data, because `Data_Mem` writes at the rising edge.

## Structure
- Shared package `Header.svh` holds:
  - `type_lsu2module_data_s` and `type_module2lsu_s`;
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - `DMEM_TOP`=11'h7FC;
  - a 1-bit state enum `type_lsu_state_e`.
- One combinational sub-module, `lsu_load_ext` (funct3 + raw word → extended data), reused for both slaves' read data.

## Test plan
- DMEM bytes 0x10..0x13 = 78 56 34 12. LW 0x10 → `load_data`=0x12345678. LB 0x13 with byte 0x93 → 0xFFFFFF93. LBU 0x13 → 0x00000093.
- SB 0x10, `store_data`=0xAABBCCDD → `stall` for exactly 1 cycle; the word at 0x10 becomes 0x123456DD; the bytes at 0x14.. are unchanged.
- SH to unaligned address 0x11 → writes DD CC to bytes 0x11..0x12; the other two bytes of the word read at 0x11 are preserved.
- SB issued, then `rst_n` pulsed low during RMW_WR → memory unchanged; state IDLE; `stall`=0.
- SW 0x8000_0004 = 0x41 → `lsu2uart_data.sel`=1, `wr_en`=1; `lsu2dmem_data` all-zero.
- LW 0x7FD, and funct3=011 → `access_fault`=1, no enables, `stall`=0.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: bus structs, funct3 codes, address limits and FSM states for the load/store unit
package lsu_ctrl_pkg;

    typedef struct packed {
        logic [31:0] dbus_addr;
        logic [31:0] dbus;
        logic        wr_en;
        logic        rd_en;
        logic        sel;
    } type_lsu2module_data_s;

    typedef struct packed {
        logic [31:0] rd_data;
    } type_module2lsu_s;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Highest byte address at which a full word still fits inside the 2 KiB data memory.
    localparam logic [10:0] DMEM_TOP = 11'h7FC;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } type_lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// lsu_load_ext: sign/zero-extends the lane-0 byte or half of a raw read word according to funct3
//   funct3  in  3   load width/sign code
//   raw     in  32  word returned by the slave, addressed byte in lane 0
//   data    out 32  extended load result
module lsu_load_ext
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]} :
               funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
               funct3 == F3_BU ? {24'h0, raw[7:0]} :
               funct3 == F3_HU ? {16'h0, raw[15:0]} :
               funct3 == F3_W  ? raw : 32'h0;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: routes memory-stage loads/stores to Data_Mem or the UART, extends load data and does sub-word DMEM stores by read-modify-write
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid, is_load, is_store    memory-stage request
//   funct3, addr, store_data        width/sign code, byte address, rs2 value
//   load_data                       extended load result (combinational)
//   stall                           holds the pipeline during the read half of a sub-word store
//   access_fault                    illegal width code or out-of-range DMEM word
//   lsu2dmem_data / dmem2lsu_data   Data_Mem request / read data
//   lsu2uart_data / uart2lsu_data   UART request / read data
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_data,
    output logic [31:0]           load_data,
    output logic                  stall,
    output logic                  access_fault,
    output type_lsu2module_data_s lsu2dmem_data,
    input  type_module2lsu_s      dmem2lsu_data,
    output type_lsu2module_data_s lsu2uart_data,
    input  type_module2lsu_s      uart2lsu_data
);

    type_lsu_state_e state, state_nx;
    logic [31:0] wbuf, wbuf_nx;
    logic [10:0] addr_q, addr_q_nx;
    logic [31:0] dmem_ext, uart_ext;
    logic        to_uart, bad_f3, bad_range, fault, active, sub_word;

    lsu_load_ext u_dmem_ext (.funct3(funct3), .raw(dmem2lsu_data.rd_data), .data(dmem_ext));
    lsu_load_ext u_uart_ext (.funct3(funct3), .raw(uart2lsu_data.rd_data), .data(uart_ext));

    assign to_uart   = addr[31];
    assign bad_f3    = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (is_store && funct3 > F3_W);
    assign bad_range = !to_uart && addr[10:0] > DMEM_TOP;
    // Requests are only decoded in IDLE; in RMW_WR the held inputs still belong to the store being finished.
    assign fault     = state == IDLE && req_valid && (is_load || is_store) && (bad_f3 || bad_range);
    assign active    = state == IDLE && req_valid && (is_load || is_store) && !fault;
    assign sub_word  = active && is_store && !to_uart && funct3 != F3_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wbuf   <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nx;
            wbuf   <= wbuf_nx;
            addr_q <= addr_q_nx;
        end
    end

    always_comb begin
        state_nx      = IDLE;
        wbuf_nx       = wbuf;
        addr_q_nx     = addr_q;
        lsu2dmem_data = '0;
        lsu2uart_data = '0;
        load_data     = 32'h0;
        stall         = 1'b0;
        access_fault  = fault;
        if (state == RMW_WR) begin
            lsu2dmem_data.dbus_addr = {21'h0, addr_q};
            lsu2dmem_data.dbus      = wbuf;
            lsu2dmem_data.wr_en     = 1'b1;
            lsu2dmem_data.sel       = 1'b1;
        end else if (active) begin
            stall     = sub_word;
            load_data = !is_load ? 32'h0 : to_uart ? uart_ext : dmem_ext;
            if (to_uart) begin
                lsu2uart_data.dbus_addr = addr;
                lsu2uart_data.dbus      = is_store ? store_data : 32'h0;
                lsu2uart_data.wr_en     = is_store;
                lsu2uart_data.rd_en     = is_load;
                lsu2uart_data.sel       = 1'b1;
            end else begin
                // A sub-word store reads the whole word now and writes the merged word next cycle.
                lsu2dmem_data.dbus_addr = addr;
                lsu2dmem_data.dbus      = is_store && !sub_word ? store_data : 32'h0;
                lsu2dmem_data.wr_en     = is_store && !sub_word;
                lsu2dmem_data.rd_en     = is_load || sub_word;
                lsu2dmem_data.sel       = 1'b1;
            end
            if (sub_word) begin
                state_nx  = RMW_WR;
                addr_q_nx = addr[10:0];
                wbuf_nx   = funct3 == F3_B ? {dmem2lsu_data.rd_data[31:8], store_data[7:0]}
                                           : {dmem2lsu_data.rd_data[31:16], store_data[15:0]};
            end
        end
    end

endmodule
